// File: rtl/rv32i_memstage_if.sv
// Signal bundle around the RV32I memory-access stage: execute-side inputs,
// the data-memory req/ack bus and the write-back outputs.
interface rv32i_memstage_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned BEW  = XLEN / 8;

    logic            valid_in;
    logic [XLEN-1:0] alu_in;
    logic [XLEN-1:0] iw_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs2_data_in;
    logic            wb_en_in;
    logic            stall_out;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [BEW-1:0]  dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    logic            valid_out;
    logic [XLEN-1:0] wb_data_out;
    logic [XLEN-1:0] iw_out;
    logic [XLEN-1:0] pc_out;
    logic            wb_en_out;
    logic            misalign_out;
    logic            bus_err_out;

    // The stage itself.
    modport slave (
        input  valid_in, alu_in, iw_in, pc_in, rs2_data_in, wb_en_in,
        input  dmem_ack, dmem_rdata,
        output stall_out,
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output valid_out, wb_data_out, iw_out, pc_out, wb_en_out,
        output misalign_out, bus_err_out
    );

    // Surrounding pipeline and data memory.
    modport master (
        output valid_in, alu_in, iw_in, pc_in, rs2_data_in, wb_en_in,
        output dmem_ack, dmem_rdata,
        input  stall_out,
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  valid_out, wb_data_out, iw_out, pc_out, wb_en_out,
        input  misalign_out, bus_err_out
    );
endinterface

// File: rtl/rv32i_memstage.sv
// RV32I memory-access stage: LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack bus,
// one access in flight, upstream stalled until it retires or times out.
module rv32i_memstage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    rv32i_memstage_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned BEW   = XLEN / 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    localparam logic [6:0]       OP_LOAD  = 7'b0000011;
    localparam logic [6:0]       OP_STORE = 7'b0100011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      off;
    logic            is_load, is_store, is_mem, misalign;
    logic [BEW-1:0]  be_c;
    logic [XLEN-1:0] wdata_c;
    logic            capture, ack_hit, timeout_hit;

    // Captured request and pending-retire context
    logic            req_q, req_d, we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [BEW-1:0]  be_q, be_d;
    logic [XLEN-1:0] alu_q, alu_d, iw_q, iw_d, pc_q, pc_d;
    logic [2:0]      f3_q, f3_d;
    logic            wben_q, wben_d;

    // Write-back outputs
    logic            valid_q, valid_d, mis_q, mis_d, berr_q, berr_d;
    logic            wbeno_q, wbeno_d;
    logic [XLEN-1:0] wbdata_q, wbdata_d, iwo_q, iwo_d, pco_q, pco_d;

    logic [XLEN-1:0] ld_shift, ld_data;

    // Decode: undefined funct3 on a load/store opcode falls back to non-mem.
    always_comb begin
        opcode   = bus.iw_in[6:0];
        funct3   = bus.iw_in[14:12];
        off      = bus.alu_in[1:0];
        is_load  = (opcode == OP_LOAD) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store = (opcode == OP_STORE) && (funct3 inside {3'b000, 3'b001, 3'b010});
        is_mem   = is_load | is_store;
        misalign = 1'b0;
        be_c     = 4'b1111;
        wdata_c  = bus.rs2_data_in;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << off;
                wdata_c = {4{bus.rs2_data_in[7:0]}};
            end
            2'b01: begin
                misalign = off[0];
                be_c     = 4'b0011 << off;
                wdata_c  = {2{bus.rs2_data_in[15:0]}};
            end
            default: misalign = (off != 2'b00);
        endcase
        misalign = misalign & is_mem;
    end

    assign capture     = (state_q == S_IDLE) && bus.valid_in && is_mem && !misalign;
    assign ack_hit     = (state_q == S_BUSY) && bus.dmem_ack;
    assign timeout_hit = (state_q == S_BUSY) && !bus.dmem_ack && (cnt_q == CNT_LAST);
    assign bus.stall_out = (state_q == S_BUSY) || capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                if (ack_hit || timeout_hit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load lane extraction from the byte offset of the captured address
    always_comb begin
        ld_shift = bus.dmem_rdata >> {alu_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    always_comb begin
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        alu_d    = alu_q;
        f3_d     = f3_q;
        iw_d     = iw_q;
        pc_d     = pc_q;
        wben_d   = wben_q;
        valid_d  = 1'b0;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        wbdata_d = wbdata_q;
        iwo_d    = iwo_q;
        pco_d    = pco_q;
        wbeno_d  = wbeno_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {bus.alu_in[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    alu_d   = bus.alu_in;
                    f3_d    = funct3;
                    iw_d    = bus.iw_in;
                    pc_d    = bus.pc_in;
                    wben_d  = bus.wb_en_in;
                end else begin
                    valid_d  = bus.valid_in;
                    mis_d    = bus.valid_in & misalign;
                    wbdata_d = bus.alu_in;
                    iwo_d    = bus.iw_in;
                    pco_d    = bus.pc_in;
                    wbeno_d  = bus.wb_en_in & ~misalign & ~is_store;
                end
            end
            S_BUSY: begin
                if (ack_hit || timeout_hit) begin
                    req_d    = 1'b0;
                    valid_d  = 1'b1;
                    berr_d   = timeout_hit;
                    iwo_d    = iw_q;
                    pco_d    = pc_q;
                    wbdata_d = (ack_hit && !we_q) ? ld_data : alu_q;
                    wbeno_d  = ack_hit & ~we_q & wben_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            alu_q    <= '0;
            f3_q     <= '0;
            iw_q     <= '0;
            pc_q     <= '0;
            wben_q   <= 1'b0;
            valid_q  <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
            wbdata_q <= '0;
            iwo_q    <= '0;
            pco_q    <= '0;
            wbeno_q  <= 1'b0;
        end else begin
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            alu_q    <= alu_d;
            f3_q     <= f3_d;
            iw_q     <= iw_d;
            pc_q     <= pc_d;
            wben_q   <= wben_d;
            valid_q  <= valid_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
            wbdata_q <= wbdata_d;
            iwo_q    <= iwo_d;
            pco_q    <= pco_d;
            wbeno_q  <= wbeno_d;
        end
    end

    assign bus.dmem_req     = req_q;
    assign bus.dmem_we      = we_q;
    assign bus.dmem_addr    = addr_q;
    assign bus.dmem_be      = be_q;
    assign bus.dmem_wdata   = wdata_q;
    assign bus.valid_out    = valid_q;
    assign bus.wb_data_out  = wbdata_q;
    assign bus.iw_out       = iwo_q;
    assign bus.pc_out       = pco_q;
    assign bus.wb_en_out    = wbeno_q;
    assign bus.misalign_out = mis_q;
    assign bus.bus_err_out  = berr_q;
endmodule

// File: tb/tb_rv32i_memstage.sv
// Scoreboarded random bench for rv32i_memstage: driver, memory responder and
// retirement monitor run as separate processes against a byte-level model.
module tb_rv32i_memstage;
    localparam int unsigned TIMEOUT = 16;
    localparam int          N_RAND  = 200;

    typedef struct {
        logic [31:0] wb_data;
        logic [31:0] iw;
        logic [31:0] pc;
        logic        wb_en;
        logic        mis;
        logic        berr;
    } exp_t;

    typedef struct {
        int          delay;
        int          req_cycles;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } plan_t;

    logic clk = 1'b0;
    logic reset;
    rv32i_memstage_if bus ();

    rv32i_memstage #(.TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    resp_en = 1'b1;
    bit    man_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: classify, then work byte-by-byte on the addressed lanes.
    function automatic void model(input logic [31:0] iw, input logic [31:0] alu,
                                  input logic [31:0] rs2, input logic [31:0] pc,
                                  input logic wb_en, input int delay, input logic [31:0] rdata,
                                  output exp_t e, output bit acc, output plan_t p,
                                  output int stall_exp);
        int          f3, size, off;
        bit          ld, st, sgn;
        logic [63:0] val;
        f3 = int'(iw[14:12]);
        ld = 1'b0; st = 1'b0; sgn = 1'b0; size = 0;
        if (iw[6:0] == 7'h03) begin
            case (f3)
                0: begin ld = 1; size = 1; sgn = 1; end
                1: begin ld = 1; size = 2; sgn = 1; end
                2: begin ld = 1; size = 4; end
                4: begin ld = 1; size = 1; end
                5: begin ld = 1; size = 2; end
                default: ;
            endcase
        end else if (iw[6:0] == 7'h23) begin
            case (f3)
                0: begin st = 1; size = 1; end
                1: begin st = 1; size = 2; end
                2: begin st = 1; size = 4; end
                default: ;
            endcase
        end
        e.wb_data = alu; e.iw = iw; e.pc = pc; e.wb_en = wb_en; e.mis = 1'b0; e.berr = 1'b0;
        acc = 1'b0; stall_exp = 0;
        p.delay = delay; p.rdata = rdata; p.req_cycles = 0;
        p.addr = '0; p.wdata = '0; p.be = '0; p.we = st;
        if (!(ld || st)) return;
        e.wb_en = 1'b0;
        off = int'(alu[1:0]);
        if ((off % size) != 0) begin
            e.mis = 1'b1;
            return;
        end
        acc = 1'b1;
        p.addr = alu - 32'(off);
        for (int i = 0; i < size; i++) p.be[off + i] = 1'b1;
        for (int j = 0; j < 4; j++) p.wdata[8*j +: 8] = rs2[8*(j % size) +: 8];
        if (delay >= int'(TIMEOUT)) begin
            e.berr = 1'b1;
            p.req_cycles = TIMEOUT;
            stall_exp = TIMEOUT + 1;
        end else begin
            p.req_cycles = delay + 1;
            stall_exp = delay + 2;
            if (ld) begin
                val = '0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = rdata[8*(off + i) +: 8];
                if (sgn && val[8*size - 1]) for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
                e.wb_data = val[31:0];
                e.wb_en = wb_en;
            end
        end
    endfunction

    task automatic issue(input logic [31:0] iw, input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic wb_en, input int delay,
                         input logic [31:0] rdata);
        exp_t  e;
        plan_t p;
        bit    acc, s, seen, done;
        int    se, stalls;
        model(iw, alu, rs2, pc, wb_en, delay, rdata, e, acc, p, se);
        exp_q.push_back(e);
        if (acc) plan_q.push_back(p);
        bus.valid_in = 1'b1; bus.iw_in = iw; bus.alu_in = alu;
        bus.rs2_data_in = rs2; bus.pc_in = pc; bus.wb_en_in = wb_en;
        stalls = 0; seen = 1'b0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            s = bus.stall_out;
            @(posedge clk);
            #1;
            if (!s) done = 1'b1;
            else begin
                stalls++;
                if (bus.dmem_req) seen = 1'b1;
                else if (seen) done = 1'b1;
            end
        end
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL issue_hang: iw 0x%08h alu 0x%08h never accepted", iw, alu);
        end
        check("stall_cycles", 32'(stalls), 32'(se));
        bus.valid_in = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.valid_in = 1'b0;
        bus.alu_in = $urandom; bus.iw_in = $urandom; bus.pc_in = $urandom;
        bus.rs2_data_in = $urandom; bus.wb_en_in = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_iw(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = op;
        w[14:12] = f3;
        return w;
    endfunction

    // Retirement monitor
    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.valid_out) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL retire: unexpected valid_out, iw 0x%08h at %0t", bus.iw_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_data", bus.wb_data_out, mon_e.wb_data);
                check("iw_out", bus.iw_out, mon_e.iw);
                check("pc_out", bus.pc_out, mon_e.pc);
                check("wb_en_out", 32'(bus.wb_en_out), 32'(mon_e.wb_en));
                check("misalign_out", 32'(bus.misalign_out), 32'(mon_e.mis));
                check("bus_err_out", 32'(bus.bus_err_out), 32'(mon_e.berr));
            end
        end else begin
            check("flags_no_retire", 32'({bus.misalign_out, bus.bus_err_out}), 32'h0);
        end
    end

    // Data-memory responder
    plan_t r_cur;
    bit    r_active, r_late;
    int    r_cnt;
    initial begin
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        r_active = 1'b0; r_late = 1'b0; r_cnt = 0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                bus.dmem_ack = man_ack; bus.dmem_rdata = '0;
                r_active = 1'b0; r_late = 1'b0;
            end else if (bus.dmem_req) begin
                if (!r_active) begin
                    r_active = 1'b1; r_cnt = 0;
                    if (plan_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL bus_req: unexpected request addr 0x%08h", bus.dmem_addr);
                        r_cur.delay = 0; r_cur.req_cycles = 1; r_cur.rdata = '0;
                    end else begin
                        r_cur = plan_q.pop_front();
                        check("dmem_addr", bus.dmem_addr, r_cur.addr);
                        check("dmem_be", 32'(bus.dmem_be), 32'(r_cur.be));
                        check("dmem_we", 32'(bus.dmem_we), 32'(r_cur.we));
                        if (r_cur.we) check("dmem_wdata", bus.dmem_wdata, r_cur.wdata);
                    end
                end
                if (r_cnt == r_cur.delay) begin
                    bus.dmem_ack = 1'b1; bus.dmem_rdata = r_cur.rdata;
                end else begin
                    bus.dmem_ack = 1'b0; bus.dmem_rdata = $urandom;
                end
                r_cnt++;
            end else begin
                if (r_active) begin
                    check("req_cycles", 32'(r_cnt), 32'(r_cur.req_cycles));
                    r_late = (r_cur.delay >= int'(TIMEOUT));
                    r_active = 1'b0;
                end
                // a stray ack after an abort must be ignored while idle
                bus.dmem_ack = r_late; r_late = 1'b0;
                bus.dmem_rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] alu;
        int          cls, dly;
        bus.valid_in = 1'b0; bus.alu_in = '0; bus.iw_in = '0; bus.pc_in = '0;
        bus.rs2_data_in = '0; bus.wb_en_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", 32'(bus.valid_out), 32'h0);
        check("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
        check("rst_stall", 32'(bus.stall_out), 32'h0);
        check("rst_wb_data", bus.wb_data_out, 32'h0);
        check("rst_iw_pc", bus.iw_out | bus.pc_out, 32'h0);
        check("rst_flags", 32'({bus.wb_en_out, bus.misalign_out, bus.bus_err_out}), 32'h0);
        check("rst_bus", bus.dmem_addr | bus.dmem_wdata | 32'(bus.dmem_be), 32'h0);
        reset = 1'b0;
        idle_cycle();

        issue(mk_iw(7'h13, 3'd0), 32'h0000_1234, 32'h0, 32'h0000_0100, 1'b1, 0, 32'h0);
        issue(mk_iw(7'h03, 3'd0), 32'h0000_0103, 32'h0, 32'h0000_0104, 1'b1, 0, 32'h80AA_BBCC);
        issue(mk_iw(7'h23, 3'd1), 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0108, 1'b1, 3, 32'h0);
        issue(mk_iw(7'h03, 3'd2), 32'h0000_0105, 32'h0, 32'h0000_010C, 1'b1, 0, 32'h0);
        issue(mk_iw(7'h03, 3'd2), 32'h0000_0200, 32'h0, 32'h0000_0110, 1'b1, 1000, 32'h0);
        issue(mk_iw(7'h03, 3'd5), 32'h0000_0302, 32'h0, 32'h0000_0114, 1'b1,
              int'(TIMEOUT) - 1, 32'h8765_4321);
        issue(mk_iw(7'h03, 3'd3), 32'h0000_0401, 32'h0, 32'h0000_0118, 1'b1, 0, 32'h0);
        issue(mk_iw(7'h23, 3'd0), 32'h0000_0501, 32'hCAFE_F00D, 32'h0000_011C, 1'b1, 0, 32'h0);

        for (int n = 0; n < N_RAND; n++) begin
            cls = int'($urandom_range(0, 9));
            if (cls < 3) begin
                op = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33;
                f3 = 3'($urandom_range(0, 7));
            end else begin
                op = (cls < 7) ? 7'h03 : 7'h23;
                f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                 : 3'($urandom_range(0, 2));
            end
            alu = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            dly = ($urandom_range(0, 24) == 0) ? int'(TIMEOUT) + int'($urandom_range(0, 5))
                                               : int'($urandom_range(0, 4));
            issue(mk_iw(op, f3), alu, $urandom, $urandom, 1'($urandom_range(0, 1)), dly, $urandom);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end

        // Reset in the middle of an access, followed by a stale ack
        idle_cycle();
        idle_cycle();
        resp_en = 1'b0; man_ack = 1'b0;
        bus.valid_in = 1'b1; bus.iw_in = mk_iw(7'h03, 3'd2); bus.alu_in = 32'h0000_0400;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        check("rst_mid_req_up", 32'(bus.dmem_req), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_req", 32'(bus.dmem_req), 32'h0);
        check("rst_mid_stall", 32'(bus.stall_out), 32'h0);
        check("rst_mid_valid", 32'(bus.valid_out), 32'h0);
        reset = 1'b0; man_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("late_ack_req", 32'(bus.dmem_req), 32'h0);
        check("late_ack_stall", 32'(bus.stall_out), 32'h0);
        man_ack = 1'b0;
        @(posedge clk);
        #1;
        resp_en = 1'b1;
        idle_cycle();
        issue(mk_iw(7'h13, 3'd0), 32'h0000_0042, 32'h0, 32'h0000_0200, 1'b1, 0, 32'h0);
        issue(mk_iw(7'h03, 3'd1), 32'h0000_0602, 32'h0, 32'h0000_0204, 1'b1, 1, 32'h7FFF_0001);

        repeat (5) idle_cycle();
        check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        check("plan_queue_empty", 32'(plan_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
